// File: rtl/tf_call_responder.sv
// Callee side of a task/function call channel: header, serial argument beats, one response beat.
// Optional saturating call/error statistics are enabled by defining TFCALL_STATS_EN.
module tf_call_responder #(
  parameter int DW    = 8,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    req_func,
  input  logic [1:0]    req_argc,
  input  logic          req_stmt,
  input  logic          req_void,
  input  logic          arg_valid,
  output logic          arg_ready,
  input  logic [DW-1:0] arg_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic [1:0]    rsp_err,
  output logic          rsp_task
`ifdef TFCALL_STATS_EN
  ,
  output logic [CNT_W-1:0] call_count,
  output logic [CNT_W-1:0] err_count
`endif
);

  typedef enum logic [1:0] {IDLE, ARGS, EXEC, RESP} state_t;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_UNDEF   = 2'd1;
  localparam logic [1:0] ERR_ARITY   = 2'd2;
  localparam logic [1:0] ERR_CONTEXT = 2'd3;

  state_t        state_q, state_d;
  logic [2:0]    func_q, func_d;
  logic [1:0]    err_q, err_d;
  logic [1:0]    rem_q, rem_d;
  logic [1:0]    idx_q, idx_d;
  // A third beat only ever arrives on an arity error, so it is drained but not stored.
  logic [DW-1:0] arg_q [2];
  logic [DW-1:0] arg_d [2];
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic [1:0]    rsp_err_q, rsp_err_d;
  logic          rsp_task_q, rsp_task_d;

  function automatic logic [1:0] check_call(input logic [2:0] f, input logic [1:0] argc,
                                            input logic stmt, input logic vd);
    logic [1:0] arity;
    logic       is_task;
    logic       defined;
    arity   = 2'd0;
    is_task = 1'b0;
    defined = 1'b1;
    case (f)
      3'd0:    arity = 2'd2;
      3'd1:    arity = 2'd1;
      3'd2:    arity = 2'd0;
      3'd3:    begin arity = 2'd2; is_task = 1'b1; end
      3'd4:    begin arity = 2'd0; is_task = 1'b1; end
      default: defined = 1'b0;
    endcase
    if (!defined)
      return ERR_UNDEF;
    else if (argc != arity)
      return ERR_ARITY;
    else if ((!is_task && stmt && !vd) || (is_task && !stmt))
      return ERR_CONTEXT;
    else
      return ERR_OK;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      func_q     <= '0;
      err_q      <= '0;
      rem_q      <= '0;
      idx_q      <= '0;
      arg_q[0]   <= '0;
      arg_q[1]   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= '0;
      rsp_task_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      func_q     <= func_d;
      err_q      <= err_d;
      rem_q      <= rem_d;
      idx_q      <= idx_d;
      arg_q[0]   <= arg_d[0];
      arg_q[1]   <= arg_d[1];
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      rsp_task_q <= rsp_task_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    func_d     = func_q;
    err_d      = err_q;
    rem_d      = rem_q;
    idx_d      = idx_q;
    arg_d[0]   = arg_q[0];
    arg_d[1]   = arg_q[1];
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    rsp_task_d = rsp_task_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          func_d  = req_func;
          err_d   = check_call(req_func, req_argc, req_stmt, req_void);
          rem_d   = req_argc;
          idx_d   = 2'd0;
          state_d = (req_argc != 2'd0) ? ARGS : EXEC;
        end
      end
      ARGS: begin
        if (arg_valid) begin
          if (idx_q == 2'd0) arg_d[0] = arg_data;
          if (idx_q == 2'd1) arg_d[1] = arg_data;
          idx_d = idx_q + 2'd1;
          rem_d = rem_q - 2'd1;
          if (rem_q == 2'd1) state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_err_d  = err_q;
        rsp_data_d = '0;
        rsp_task_d = 1'b0;
        if (err_q == ERR_OK) begin
          case (func_q)
            3'd0:    rsp_data_d = arg_q[0] + arg_q[1];
            3'd1:    rsp_data_d = {{(DW/2){1'b0}}, arg_q[0][DW/2-2:0], 1'b0};
            3'd2:    rsp_data_d = DW'(1);
            default: rsp_task_d = 1'b1;
          endcase
        end
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // req_ready is held low while reset is asserted, rising only once it deasserts.
  assign req_ready = (state_q == IDLE) && !rst;
  assign arg_ready = (state_q == ARGS);
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_task  = rsp_task_q;

`ifdef TFCALL_STATS_EN
  logic [CNT_W-1:0] call_cnt_q;
  logic [CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      call_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else if (rsp_valid && rsp_ready) begin
      if (call_cnt_q != {CNT_W{1'b1}}) call_cnt_q <= call_cnt_q + 1'b1;
      if (rsp_err_q != ERR_OK && err_cnt_q != {CNT_W{1'b1}}) err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign call_count = call_cnt_q;
  assign err_count  = err_cnt_q;
`endif

endmodule
